// File: rtl/ex_muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// One radix-2 step per cycle; signed operations run on magnitudes and fix signs at the end.
module ex_muldiv_unit (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        EX_Start,
  input  logic [1:0]  EX_MDOp,
  input  logic [31:0] EX_OperandA,
  input  logic [31:0] EX_OperandB,
  input  logic        EX_HIWrite,
  input  logic        EX_LOWrite,
  input  logic        EX_Flush,
  output logic        MD_Busy,
  output logic        MD_Stall,
  output logic        MD_Done,
  output logic        MD_DivZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] operand;
  logic [63:0] acc;
  logic        is_div, neg_res, neg_rem, div_zero;

  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_prod;
  logic [32:0] div_trial;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [31:0] quot, rem, fix_hi, fix_lo;

  assign a_neg = EX_MDOp[0] & EX_OperandA[31];
  assign b_neg = EX_MDOp[0] & EX_OperandB[31];
  assign abs_a = a_neg ? -EX_OperandA : EX_OperandA;
  assign abs_b = b_neg ? -EX_OperandB : EX_OperandB;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // Divide: acc = {remainder, remaining dividend / growing quotient}, shifted left each step
  assign div_trial = acc[63:31];
  assign div_ge    = div_trial >= {1'b0, operand};
  assign div_sub   = div_trial[31:0] - operand;
  assign div_next  = div_ge ? {div_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

  assign mul_prod = neg_res ? -acc : acc;
  assign quot     = acc[31:0];
  assign rem      = acc[63:32];
  assign fix_lo   = is_div ? (div_zero ? 32'hFFFF_FFFF : (neg_res ? -quot : quot)) : mul_prod[31:0];
  assign fix_hi   = is_div ? (neg_rem ? -rem : rem) : mul_prod[63:32];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    MD_Busy    = 1'b0;
    case (state)
      IDLE: if (EX_Start) state_next = EX_MDOp[1] ? DIV : MUL;
      MUL, DIV: begin
        MD_Busy = 1'b1;
        if (count == 5'd0) state_next = FIX;
      end
      FIX: begin
        MD_Busy    = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (EX_Flush) state_next = IDLE;
  end

  assign MD_Stall   = MD_Busy | (EX_Start & (state == IDLE));
  assign MD_Done    = (state == DONE);
  assign MD_DivZero = MD_Done & div_zero;

  // Flush suppresses every datapath update, including a pending HI/LO commit
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      count    <= 5'd0;
      operand  <= 32'd0;
      acc      <= 64'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else if (!EX_Flush) begin
      case (state)
        IDLE: begin
          if (EX_Start) begin
            count    <= 5'd31;
            is_div   <= EX_MDOp[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= EX_MDOp[1] & (EX_OperandB == 32'd0);
            operand  <= EX_MDOp[1] ? abs_b : abs_a;
            acc      <= {32'd0, EX_MDOp[1] ? abs_a : abs_b};
          end else begin
            if (EX_HIWrite) HI <= EX_OperandA;
            if (EX_LOWrite) LO <= EX_OperandA;
          end
        end
        MUL: begin
          acc   <= mul_next;
          count <= count - 5'd1;
        end
        DIV: begin
          acc   <= div_next;
          count <= count - 5'd1;
        end
        FIX: begin
          HI <= fix_hi;
          LO <= fix_lo;
        end
        DONE: begin
          if (EX_HIWrite) HI <= EX_OperandA;
          if (EX_LOWrite) LO <= EX_OperandA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        EX_Start, EX_HIWrite, EX_LOWrite, EX_Flush;
  logic [1:0]  EX_MDOp;
  logic [31:0] EX_OperandA, EX_OperandB;
  logic        MD_Busy, MD_Stall, MD_Done, MD_DivZero;
  logic [31:0] HI, LO;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] hi_m, lo_m;

  ex_muldiv_unit dut (
    .sysclk(sysclk), .reset(reset), .EX_Start(EX_Start), .EX_MDOp(EX_MDOp),
    .EX_OperandA(EX_OperandA), .EX_OperandB(EX_OperandB),
    .EX_HIWrite(EX_HIWrite), .EX_LOWrite(EX_LOWrite), .EX_Flush(EX_Flush),
    .MD_Busy(MD_Busy), .MD_Stall(MD_Stall), .MD_Done(MD_Done), .MD_DivZero(MD_DivZero),
    .HI(HI), .LO(LO)
  );

  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Returns {div_zero, HI, LO} straight from the arithmetic definition of each op
  function automatic logic [64:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'd0) begin
      p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (op == 2'd1) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (op == 2'd2) begin
      q = a / b;
      r = a % b;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return {1'b0, r, q};
  endfunction

  // mode: 0 plain, 1 writes/start poked mid-op, 2 start with mthi/mtlo, 3 flush mid-op, 4 reset mid-op
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [64:0] exp;
    int          n, stall_cnt, done_cnt;
    exp = refModel(op, a, b);
    @(negedge sysclk);
    EX_Start    = 1'b1;
    EX_MDOp     = op;
    EX_OperandA = a;
    EX_OperandB = b;
    EX_HIWrite  = (mode == 2);
    EX_LOWrite  = (mode == 2);
    #1;
    checkOutput("stall_on_start", MD_Stall, 1);
    stall_cnt = 1;
    @(posedge sysclk); #1;
    EX_Start = 1'b0; EX_HIWrite = 1'b0; EX_LOWrite = 1'b0;
    n = 1;
    while (n < 40) begin
      if (MD_Done) break;
      if (MD_Stall) stall_cnt++;
      if (n == 1 || n == 6) checkOutput("hilo_hold", {HI, LO}, {hi_m, lo_m});
      if (n == 2) checkOutput("busy_mid", MD_Busy, 1);
      if (mode == 1 && n == 5) begin
        EX_Start = 1'b1; EX_HIWrite = 1'b1; EX_LOWrite = 1'b1;
        EX_MDOp = ~op; EX_OperandA = 32'h1234_5678; EX_OperandB = 32'd3;
      end
      if (mode == 3 && n == 10) begin
        EX_Flush = 1'b1; EX_Start = 1'b1;
        @(posedge sysclk); #1;
        EX_Flush = 1'b0; EX_Start = 1'b0;
        checkOutput("flush_busy", MD_Busy, 0);
        checkOutput("flush_hilo", {HI, LO}, {hi_m, lo_m});
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
          if (MD_Done) done_cnt++;
          @(posedge sysclk); #1;
        end
        checkOutput("flush_no_done", 64'(done_cnt), 0);
        return;
      end
      if (mode == 4 && n == 20) begin
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_hilo", {HI, LO}, 0);
        checkOutput("rst_mid_flags", {MD_Busy, MD_Done, MD_DivZero, MD_Stall}, 0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge sysclk);
        reset = 1'b1;
        return;
      end
      @(posedge sysclk); #1;
      EX_Start = 1'b0; EX_HIWrite = 1'b0; EX_LOWrite = 1'b0;
      n++;
    end
    checkOutput("done_latency", 64'(n), 34);
    checkOutput("stall_cycles", 64'(stall_cnt), 34);
    checkOutput("result_hi", HI, exp[63:32]);
    checkOutput("result_lo", LO, exp[31:0]);
    checkOutput("divzero", MD_DivZero, exp[64]);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    @(posedge sysclk); #1;
    checkOutput("done_pulse_end", {MD_Done, MD_DivZero}, 0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    EX_Start = 1'b0; EX_HIWrite = 1'b0; EX_LOWrite = 1'b0; EX_Flush = 1'b0;
    EX_MDOp = 2'd0; EX_OperandA = 32'd0; EX_OperandB = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    #2;
    checkOutput("reset_hilo", {HI, LO}, 0);
    checkOutput("reset_flags", {MD_Busy, MD_Done, MD_DivZero, MD_Stall}, 0);
    @(negedge sysclk);
    reset = 1'b1;

    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(2'd2, 32'd7, 32'd0, 0);
    applyStimulus(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(2'd3, 32'hFFFF_FFF9, 32'd0, 0);
    applyStimulus(2'd0, 32'd3, 32'd5, 3);
    applyStimulus(2'd0, 32'd3, 32'd5, 0);
    applyStimulus(2'd0, 32'd1000, 32'd77, 1);

    @(negedge sysclk);
    EX_HIWrite = 1'b1; EX_OperandA = 32'h1234_5678;
    @(posedge sysclk); #1;
    EX_HIWrite = 1'b0;
    hi_m = 32'h1234_5678;
    checkOutput("mthi_idle", HI, hi_m);

    @(negedge sysclk);
    EX_LOWrite = 1'b1; EX_Flush = 1'b1; EX_OperandA = 32'hDEAD_BEEF;
    @(posedge sysclk); #1;
    EX_LOWrite = 1'b0; EX_Flush = 1'b0;
    checkOutput("flush_over_mtlo", LO, lo_m);

    applyStimulus(2'd2, 32'd100, 32'd7, 2);
    applyStimulus(2'd2, 32'd1000, 32'd7, 4);
    applyStimulus(2'd2, 32'd1000, 32'd7, 0);

    for (int i = 0; i < 24; i++)
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), (i % 5 == 4) ? 1 : ((i % 7 == 6) ? 2 : 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 sysclk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-003 EX_Start  input  1  request to begin a multiply/divide, sampled on the rising edge.
REQ-004 EX_MDOp  input  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
REQ-005 EX_OperandA  input  32  multiplicand/dividend (rs); also mthi/mtlo data.
REQ-006 EX_OperandB  input  32  multiplier/divisor (rt).
REQ-007 EX_HIWrite  input  1  mthi: load HI from EX_OperandA.
REQ-008 EX_LOWrite  input  1  mtlo: load LO from EX_OperandA.
REQ-009 EX_Flush  input  1  abort any operation in progress.
REQ-010 MD_Busy  output  1  operation in progress.
REQ-011 MD_Stall  output  1  pipeline hold request to IF/ID, PC and ID/EX.
REQ-012 MD_Done  output  1  one-cycle pulse: result committed to HI/LO.
REQ-013 MD_DivZero  output  1  one-cycle pulse coincident with MD_Done for division by zero.
REQ-014 HI  output  32  HI register (mfhi source).
REQ-015 LO  output  32  LO register (mflo source).

Function
REQ-016 The FSM SHALL have states IDLE, MUL, DIV, FIX, DONE, with a 5-bit iteration counter.
REQ-017 In IDLE with EX_Start=1 and EX_Flush=0, the unit SHALL latch absolute-value operands (signed ops) or raw operands (unsigned ops), record result signs, load counter=31, and enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-018 MUL SHALL perform one radix-2 shift-add step per cycle into a 64-bit accumulator, for 32 cycles (counter 31 down to 0), then enter FIX.
REQ-019 DIV SHALL perform one restoring shift-subtract step per cycle, for 32 cycles, then enter FIX.
REQ-020 FIX SHALL write HI/LO on its exiting edge: product negated when signA^signB (mult); quotient negated when signA^signB, remainder takes dividend sign (div); then enter DONE.
REQ-021 DONE SHALL assert MD_Done for exactly one cycle and return to IDLE on the next edge.
REQ-022 Latency: HI/LO SHALL hold the new result 34 rising edges after the edge that sampled EX_Start (1 accept + 32 iterate + 1 fix).
REQ-023 MD_Busy SHALL be 1 in MUL, DIV, FIX; 0 in IDLE, DONE.
REQ-024 MD_Stall SHALL equal MD_Busy OR (EX_Start AND state==IDLE), combinationally, so the issuing instruction is held in EX until MD_Done.
REQ-025 EX_Start SHALL be ignored while in any state other than IDLE.
REQ-026 EX_HIWrite/EX_LOWrite SHALL update HI/LO at the edge only in IDLE or DONE; ignored while MD_Busy=1.
REQ-027 Simultaneous EX_Start and EX_HIWrite/EX_LOWrite in IDLE: EX_Start SHALL win and the write SHALL be dropped.
REQ-028 Divide by zero (EX_OperandB=0): iteration SHALL still take 32 cycles; result SHALL be LO=32'hFFFFFFFF, HI=EX_OperandA as latched; MD_DivZero SHALL pulse with MD_Done.
REQ-029 div 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0 (two's-complement wrap, no trap).
REQ-030 EX_Flush=1 in any state SHALL force IDLE at the next edge; HI/LO SHALL keep prior values; no MD_Done pulse.
REQ-031 EX_Flush has priority over EX_Start, EX_HIWrite, EX_LOWrite in the same cycle.
REQ-032 Arithmetic SHALL be exact modulo 2^64 for products and modulo 2^32 for quotient/remainder.

Reset
REQ-033 With reset low: state=IDLE, counter=0, HI=0, LO=0, MD_Busy=0, MD_Done=0, MD_DivZero=0, internal operand/accumulator registers=0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation immediately; after release the unit SHALL be in IDLE accepting EX_Start on the first edge.

Verification
REQ-035 mult A=32'hFFFFFFFF, B=32'hFFFFFFFF -> after 34 edges HI=0, LO=1, MD_Done pulse 1 cycle, MD_Stall high for 34 cycles.
REQ-036 multu A=32'hFFFFFFFF, B=2 -> HI=1, LO=32'hFFFFFFFE.
REQ-037 div A=-7 (32'hFFFFFFF9), B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); divu A=7, B=0 -> LO=32'hFFFFFFFF, HI=7, MD_DivZero pulse.
REQ-038 Start multu 3*5, EX_Flush at iteration 10 -> IDLE next edge, HI/LO unchanged, no MD_Done; new Start then completes normally.
REQ-039 EX_HIWrite with A=32'h12345678 during MUL -> HI unaffected; same write in IDLE -> HI=32'h12345678 next edge; EX_Start+EX_LOWrite together in IDLE -> LO written only by the operation result.
REQ-040 reset pulsed low at iteration 20 of divu -> all outputs 0 immediately; Start after release -> correct result 34 edges later.
